// File: rtl/aes_dec_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : aes_dec_ctrl
// Function : Sequencer for the 11-stage pipelined AES-128 decryptor: key load
//            and expansion wait, credit-based block admission, output FIFO.
//            Optional tag sideband: define AES_DEC_CTRL_TAG_EN.
// Revision : 1.0 - initial release
// ============================================================================
module aes_dec_ctrl #(
    parameter int BLOCK_LENGTH = 128,
    parameter int PIPE_LAT     = 11,
    parameter int KEY_CYCLES   = 11,
    parameter int FIFO_DEPTH   = 4,
    parameter int TAG_W        = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    key_load,
    input  logic [BLOCK_LENGTH-1:0] key_in,
    output logic                    key_busy,
    output logic [BLOCK_LENGTH-1:0] key_out,
    output logic                    fsm_en,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [BLOCK_LENGTH-1:0] in_data,
    output logic                    pipe_en,
    output logic [BLOCK_LENGTH-1:0] pipe_in,
    input  logic [BLOCK_LENGTH-1:0] pipe_out,
    output logic                    out_valid,
    input  logic                    out_ready,
`ifdef AES_DEC_CTRL_TAG_EN
    input  logic [TAG_W-1:0]        in_tag,
    output logic [TAG_W-1:0]        out_tag,
`endif
    output logic [BLOCK_LENGTH-1:0] out_data
);

    typedef enum logic [1:0] {
        S_NOKEY  = 2'd0,
        S_EXPAND = 2'd1,
        S_RUN    = 2'd2,
        S_DRAIN  = 2'd3
    } state_t;

    localparam int KCNT_W = $clog2(KEY_CYCLES + 1);
    localparam int INF_W  = $clog2(PIPE_LAT + 1);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int SUM_W  = ((INF_W > FCNT_W) ? INF_W : FCNT_W) + 1;

    generate
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TAG_W < 1 ||
            PIPE_LAT < 1 || KEY_CYCLES < 1) begin : g_bad_param
            $error("aes_dec_ctrl: illegal parameter combination");
        end
    endgenerate

    state_t                  state_q;
    logic [BLOCK_LENGTH-1:0] key_q;
    logic [BLOCK_LENGTH-1:0] pend_q;
    logic                    fsm_en_q;
    logic [KCNT_W-1:0]       kcnt_q;
    logic [INF_W-1:0]        inflight_q;
    logic [INF_W-1:0]        inflight_d;
    logic [PIPE_LAT-1:0]     vld_q;
    logic [BLOCK_LENGTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]        wptr_q;
    logic [PTR_W-1:0]        rptr_q;
    logic [FCNT_W-1:0]       fcnt_q;
    logic [FCNT_W-1:0]       fcnt_d;
    logic [SUM_W-1:0]        credit_sum;
    logic                    emerge;
    logic                    push;
    logic                    pop;

    // Every admitted block holds one credit until it leaves the FIFO, so the
    // FIFO can never be asked to take more than it has room for.
    assign credit_sum = SUM_W'(inflight_q) + SUM_W'(fcnt_q);
    assign in_ready   = (state_q == S_RUN) && (credit_sum < SUM_W'(FIFO_DEPTH));
    assign pipe_en    = in_valid && in_ready;
    assign pipe_in    = in_data;
    assign key_busy   = (state_q == S_EXPAND) || (state_q == S_DRAIN);
    assign key_out    = key_q;
    assign fsm_en     = fsm_en_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_NOKEY;
            key_q    <= '0;
            pend_q   <= '0;
            fsm_en_q <= 1'b0;
            kcnt_q   <= '0;
        end else begin
            fsm_en_q <= 1'b0;
            case (state_q)
                S_NOKEY: begin
                    if (key_load) begin
                        key_q    <= key_in;
                        fsm_en_q <= 1'b1;
                        kcnt_q   <= KCNT_W'(KEY_CYCLES - 1);
                        state_q  <= S_EXPAND;
                    end
                end
                S_EXPAND: begin
                    if (key_load) begin
                        key_q    <= key_in;
                        fsm_en_q <= 1'b1;
                        kcnt_q   <= KCNT_W'(KEY_CYCLES - 1);
                    end else if (kcnt_q == '0) begin
                        state_q <= S_RUN;
                    end else begin
                        kcnt_q <= kcnt_q - 1'b1;
                    end
                end
                S_RUN: begin
                    if (key_load) begin
                        pend_q  <= key_in;
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // A request arriving on the switch-over cycle is the newest.
                    if (inflight_q == '0) begin
                        key_q    <= key_load ? key_in : pend_q;
                        fsm_en_q <= 1'b1;
                        kcnt_q   <= KCNT_W'(KEY_CYCLES - 1);
                        state_q  <= S_EXPAND;
                    end else if (key_load) begin
                        pend_q <= key_in;
                    end
                end
                default: state_q <= S_NOKEY;
            endcase
        end
    end

    assign emerge = vld_q[PIPE_LAT-1];

    always_comb begin
        inflight_d = inflight_q;
        if (pipe_en && !emerge) begin
            inflight_d = inflight_q + 1'b1;
        end else if (!pipe_en && emerge) begin
            inflight_d = inflight_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q      <= '0;
            inflight_q <= '0;
        end else begin
            vld_q[0] <= pipe_en;
            for (int i = 1; i < PIPE_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
            inflight_q <= inflight_d;
        end
    end

    assign push      = emerge;
    assign out_valid = (fcnt_q != '0);
    assign pop       = out_valid && out_ready;
    assign out_data  = mem_q[rptr_q];

    always_comb begin
        fcnt_d = fcnt_q;
        if (push && !pop) begin
            fcnt_d = fcnt_q + 1'b1;
        end else if (pop && !push) begin
            fcnt_d = fcnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            fcnt_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push) begin
                mem_q[wptr_q] <= pipe_out;
                wptr_q        <= wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            fcnt_q <= fcnt_d;
        end
    end

`ifdef AES_DEC_CTRL_TAG_EN
    logic [TAG_W-1:0] tag_sr_q  [PIPE_LAT];
    logic [TAG_W-1:0] tag_mem_q [FIFO_DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                tag_sr_q[i] <= '0;
            end
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                tag_mem_q[i] <= '0;
            end
        end else begin
            tag_sr_q[0] <= in_tag;
            for (int i = 1; i < PIPE_LAT; i++) begin
                tag_sr_q[i] <= tag_sr_q[i-1];
            end
            if (push) begin
                tag_mem_q[wptr_q] <= tag_sr_q[PIPE_LAT-1];
            end
        end
    end

    assign out_tag = tag_mem_q[rptr_q];
`endif

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(push && !pop && (fcnt_q == FCNT_W'(FIFO_DEPTH))));

    a_key_stable: assert property (@(posedge clk) disable iff (!rst)
        (inflight_q != '0) |=> (key_q == $past(key_q)));

endmodule
`default_nettype wire

// File: tb/tb_aes_dec_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_dec_ctrl
// Function : Scoreboard bench for aes_dec_ctrl with a behavioural stand-in for
//            the 11-stage decryption pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_dec_ctrl;

    localparam int PL = 11;
    localparam logic [127:0] KEY0 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KEY1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT0  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT0  = 128'h00112233445566778899aabbccddeeff;
    // Stand-in cipher: key dependent, and maps the FIPS-197 vector correctly.
    localparam logic [127:0] MIX  = CT0 ^ KEY0 ^ PT0;

    logic         clk = 1'b0;
    logic         rst;
    logic         key_load;
    logic [127:0] key_in;
    logic         key_busy;
    logic [127:0] key_out;
    logic         fsm_en;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         pipe_en;
    logic [127:0] pipe_in;
    logic [127:0] pipe_out;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
`ifdef AES_DEC_CTRL_TAG_EN
    logic [3:0]   in_tag = 4'd0;
    logic [3:0]   out_tag;
`endif

    int total = 0;
    int bad = 0;
    int cyc_n = 0;
    int fsm_pulses = 0;
    int hs_n = 0;
    int pops = 0;
    int last_hs = 0;
    logic [127:0] cur_key = '0;
    logic [127:0] exp_q [$];
    logic [127:0] stg [PL];

    aes_dec_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .key_load  (key_load),
        .key_in    (key_in),
        .key_busy  (key_busy),
        .key_out   (key_out),
        .fsm_en    (fsm_en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .pipe_en   (pipe_en),
        .pipe_in   (pipe_in),
        .pipe_out  (pipe_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef AES_DEC_CTRL_TAG_EN
        .in_tag    (in_tag),
        .out_tag   (out_tag),
`endif
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] dec(input logic [127:0] d, input logic [127:0] k);
        return d ^ k ^ MIX;
    endfunction

    always @(posedge clk) begin
        stg[0] <= dec(pipe_in, key_out);
        for (int i = 1; i < PL; i++) begin
            stg[i] <= stg[i-1];
        end
    end
    assign pipe_out = stg[PL-1];

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // One clock cycle: sample between edges, score traffic, advance to next negedge.
    task automatic cyc();
        #2;
        if (fsm_en) fsm_pulses++;
        if (in_valid && in_ready) begin
            exp_q.push_back(dec(in_data, cur_key));
            hs_n++;
            last_hs = cyc_n;
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("spurious_out", 128'(out_valid), 128'(0));
            else chk("out_data", out_data, exp_q.pop_front());
            pops++;
        end
        @(negedge clk);
        cyc_n++;
    endtask

    task automatic load_key(input logic [127:0] k);
        int p0;
        p0       = fsm_pulses;
        key_in   = k;
        key_load = 1'b1;
        cur_key  = k;
        cyc();
        key_load = 1'b0;
        repeat (10) cyc();
        #1;
        chk("expand_busy", 128'(key_busy), 128'(1));
        chk("expand_ready", 128'(in_ready), 128'(0));
        cyc();
        #1;
        chk("run_ready", 128'(in_ready), 128'(1));
        chk("run_busy", 128'(key_busy), 128'(0));
        chk("key_out", key_out, k);
        chk("fsm_pulses", 128'(fsm_pulses - p0), 128'(1));
    endtask

    task automatic wait_drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 100) begin
            cyc();
            g++;
        end
        chk("drain_in_time", 128'(g < 100), 128'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, n0, g, t5, p, p0, early, ov;
        rst = 1'b0; key_load = 1'b0; key_in = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_key_out", key_out, 128'(0));
        chk("rst_fsm_en", 128'(fsm_en), 128'(0));
        chk("rst_key_busy", 128'(key_busy), 128'(0));
        chk("rst_in_ready", 128'(in_ready), 128'(0));
        chk("rst_pipe_en", 128'(pipe_en), 128'(0));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_out_data", out_data, 128'(0));
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b1;
        #1;
        chk("nokey_ready", 128'(in_ready), 128'(0));
        cyc();
        in_valid = 1'b0;

        load_key(KEY0);

        // FIPS-197 block: plaintext appears PIPE_LAT+1 cycles after admission.
        out_ready = 1'b1;
        in_data   = CT0;
        in_valid  = 1'b1;
        cyc();
        in_valid = 1'b0;
        early = 0;
        for (int i = 1; i <= 11; i++) begin
            #1;
            if (out_valid) early++;
            cyc();
        end
        chk("fips_not_early", 128'(early), 128'(0));
        #1;
        chk("fips_valid_at_12", 128'(out_valid), 128'(1));
        chk("fips_plaintext", out_data, PT0);
        cyc();

        // 20-block stream: four credits recycle every PIPE_LAT+2 cycles.
        c0 = cyc_n; n0 = hs_n; p0 = pops; g = 0;
        while (hs_n - n0 < 20 && g < 400) begin
            in_data  = {$urandom, $urandom, $urandom, $urandom};
            in_valid = 1'b1;
            cyc();
            g++;
        end
        in_valid = 1'b0;
        chk("stream_admit_in_time", 128'(g < 400), 128'(1));
        chk("stream_span", 128'(last_hs - c0), 128'(55));
        wait_drain();
        chk("stream_outputs", 128'(pops - p0), 128'(20));

        // Backpressure: exactly FIFO_DEPTH blocks admitted and buffered.
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_data  = {$urandom, $urandom, $urandom, $urandom};
            in_valid = 1'b1;
            #1;
            chk("bp_ready", 128'(in_ready), 128'(i < 4));
            cyc();
        end
        in_valid = 1'b0;
        repeat (10) cyc();
        #1;
        chk("bp_buffered_valid", 128'(out_valid), 128'(1));
        chk("bp_full_ready", 128'(in_ready), 128'(0));
        out_ready = 1'b1;
        p0 = pops;
        repeat (4) cyc();
        chk("bp_drained", 128'(pops - p0), 128'(4));
        #1;
        chk("bp_empty", 128'(out_valid), 128'(0));

        // Re-key with five blocks admitted under the old key.
        n0 = hs_n; p0 = pops; g = 0;
        while (hs_n - n0 < 5 && g < 100) begin
            in_data  = {$urandom, $urandom, $urandom, $urandom};
            in_valid = 1'b1;
            cyc();
            g++;
        end
        in_valid = 1'b0;
        chk("rekey_admit_in_time", 128'(g < 100), 128'(1));
        t5 = last_hs;
        key_in   = KEY1;
        key_load = 1'b1;
        cyc();
        key_load = 1'b0;
        cur_key  = KEY1;
        #1;
        chk("drain_ready", 128'(in_ready), 128'(0));
        chk("drain_busy", 128'(key_busy), 128'(1));
        p = fsm_pulses;
        repeat (10) cyc();
        #1;
        chk("drain_key_held", key_out, KEY0);
        cyc();
        #1;
        chk("drain_cycle", 128'(cyc_n - t5), 128'(13));
        chk("no_early_fsm_en", 128'(fsm_pulses - p), 128'(0));
        chk("fsm_en_after_drain", 128'(fsm_en), 128'(1));
        chk("new_key_out", key_out, KEY1);
        chk("old_blocks_done", 128'(pops - p0), 128'(5));
        c0 = cyc_n; g = 0;
        while (!in_ready && g < 40) begin
            cyc();
            g++;
        end
        chk("rekey_ready_delay", 128'(cyc_n - c0), 128'(11));
        in_data  = {$urandom, $urandom, $urandom, $urandom};
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        wait_drain();
        chk("rekey_block_out", 128'(pops - p0), 128'(6));

        // Asynchronous reset with three blocks in flight.
        for (int i = 0; i < 3; i++) begin
            in_data  = {$urandom, $urandom, $urandom, $urandom};
            in_valid = 1'b1;
            cyc();
        end
        in_valid = 1'b0;
        cyc();
        cyc();
        #1;
        rst = 1'b0;
        #1;
        chk("midrst_out_valid", 128'(out_valid), 128'(0));
        chk("midrst_in_ready", 128'(in_ready), 128'(0));
        chk("midrst_key_out", key_out, 128'(0));
        exp_q.delete();
        cyc();
        rst = 1'b1;
        ov = 0;
        repeat (20) begin
            #1;
            if (out_valid) ov++;
            cyc();
        end
        chk("no_stale_output", 128'(ov), 128'(0));
        chk("post_rst_nokey", 128'(in_ready), 128'(0));
        load_key(KEY0);
        p0 = pops;
        in_data  = CT0;
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        wait_drain();
        chk("post_rst_fips", 128'(pops - p0), 128'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
